// File: rtl/alu32_seq_if.sv
// rtl/alu32_seq_if.sv - request/result bundle between an issuing stage and alu32_seq
interface alu32_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic [31:0] res_hi;
  logic        zero;

  modport master (
    output start, op, a, b,
    input  busy, done, res, res_hi, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, res, res_hi, zero
  );
endinterface

// File: rtl/alu32_seq.sv
// rtl/alu32_seq.sv - registered handshaked 32-bit ALU stage, optional shift-add multiplier under ALU32_MULT_EN
module and_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = a_i & b_i;
endmodule

module alu32_seq (
  input  logic clk,
  input  logic rst_n,
  alu32_seq_if.slave bus
);
  // Width is pinned by and_32.
  localparam int W = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULT = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2, FIN = 2'd3} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic         busy_q, busy_d, done_q, done_d, zero_q, zero_d;
  logic [W-1:0] res_q, res_d, res_hi_q, res_hi_d;
  logic [W-1:0] and_y, alu_y;

`ifdef ALU32_MULT_EN
  // Product register: upper half is the accumulator, lower half the shrinking multiplier.
  logic [2*W-1:0] prod_q, prod_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [W:0]     acc_sum;
`endif

  and_32 u_and (.a_i(a_q), .b_i(b_q), .y_o(and_y));

  // Single-cycle result from latched operands; reserved codes (and MULT when not built) give 0.
  always_comb begin
    alu_y = '0;
    case (op_q)
      OP_AND:  alu_y = and_y;
      OP_OR:   alu_y = a_q | b_q;
      OP_ADD:  alu_y = a_q + b_q;
      OP_SUB:  alu_y = a_q - b_q;
      OP_SLT:  alu_y = {{(W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_y = '0;
    endcase
  end

`ifdef ALU32_MULT_EN
  // One shift-add step: conditionally add multiplicand into the 33-bit accumulator.
  always_comb begin
    acc_sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  end
`endif

  // Next-state and output-register logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    zero_d   = zero_q;
`ifdef ALU32_MULT_EN
    prod_d   = prod_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d    = bus.a;
          b_d    = bus.b;
          op_d   = bus.op;
          busy_d = 1'b1;
`ifdef ALU32_MULT_EN
          if (bus.op == OP_MULT) begin
            state_d = MUL;
            prod_d  = {{W{1'b0}}, bus.b};
            cnt_d   = 6'd0;
          end else begin
            state_d = EXEC;
          end
`else
          state_d = EXEC;
`endif
        end
      end
      EXEC: begin
        res_d    = alu_y;
        res_hi_d = '0;
        zero_d   = (alu_y == '0);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
`ifdef ALU32_MULT_EN
      MUL: begin
        prod_d = {acc_sum, prod_q[W-1:1]};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIN;
      end
      FIN: begin
        res_d    = prod_q[W-1:0];
        res_hi_d = prod_q[2*W-1:W];
        zero_d   = (prod_q[W-1:0] == '0);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any operation and clears results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b1;
`ifdef ALU32_MULT_EN
      prod_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      zero_q   <= zero_d;
`ifdef ALU32_MULT_EN
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.res    = res_q;
  assign bus.res_hi = res_hi_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_alu32_seq.sv
// tb/tb_alu32_seq.sv - directed vector bench for alu32_seq (follows ALU32_MULT_EN)
module tb_alu32_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu32_seq_if bus();

  alu32_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

`ifdef ALU32_MULT_EN
  localparam int KIGN = 5;
  localparam int KRST = 10;
  localparam logic [2:0] LONG_OP = 3'b011;
`else
  localparam int KIGN = 1;
  localparam int KRST = 1;
  localparam logic [2:0] LONG_OP = 3'b000;
`endif

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~a;
    bus.b = b ^ 32'h5A5A5A5A;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.done === 1'b1) break;
    end
  endtask

  initial begin
    int e;
    int base;

    vecs.push_back('{3'b000, 32'h00000039, 32'h00000003, 32'h00000001, 32'h0, 1'b0, 1});
    vecs.push_back('{3'b000, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 32'h0, 1'b1, 1});
    vecs.push_back('{3'b001, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0, 32'h0, 1'b0, 1});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1});
    vecs.push_back('{3'b010, 32'h12345678, 32'h11111111, 32'h23456789, 32'h0, 1'b0, 1});
    vecs.push_back('{3'b110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0, 1'b0, 1});
    vecs.push_back('{3'b110, 32'h00000007, 32'h00000007, 32'h00000000, 32'h0, 1'b1, 1});
    vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1});
    vecs.push_back('{3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1});
    vecs.push_back('{3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 32'h0, 1'b0, 1});
    vecs.push_back('{3'b100, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0, 1'b1, 1});
    vecs.push_back('{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b1, 1});
`ifdef ALU32_MULT_EN
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33});
    vecs.push_back('{3'b011, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b1, 33});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33});
    vecs.push_back('{3'b011, 32'h00000003, 32'h00000004, 32'h0000000C, 32'h00000000, 1'b0, 33});
`else
    vecs.push_back('{3'b011, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0, 1'b1, 1});
`endif

    // Reset, with start held high to show reset dominates.
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.op = 3'b001;
    bus.a = 32'hFFFFFFFF;
    bus.b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_res", bus.res, 32'h0);
    chk("reset_res_hi", bus.res_hi, 32'h0);
    chk("reset_zero", bus.zero, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_after_accept", i), bus.busy, 1'b1);
      wait_done(e);
      chk($sformatf("v%0d_latency", i), e, vecs[i].lat);
      chk($sformatf("v%0d_res", i), bus.res, vecs[i].res);
      chk($sformatf("v%0d_res_hi", i), bus.res_hi, vecs[i].hi);
      chk($sformatf("v%0d_zero", i), bus.zero, vecs[i].zero);
      chk($sformatf("v%0d_busy_at_done", i), bus.busy, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_one_cycle", i), bus.done, 1'b0);
      chk($sformatf("v%0d_res_held", i), bus.res, vecs[i].res);
    end

    // Start pulsed while busy must be ignored, not queued.
    base = done_cnt;
    issue(LONG_OP, 32'hFFFFFFFF, (LONG_OP == 3'b000) ? 32'h00000001 : 32'hFFFFFFFF);
    repeat (KIGN - 1) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b1;
    bus.op = 3'b000;
    bus.a = 32'hFFFFFFFF;
    bus.b = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("ign_done_count", done_cnt - base, 1);
    chk("ign_res", bus.res, 32'h00000001);
`ifdef ALU32_MULT_EN
    chk("ign_res_hi", bus.res_hi, 32'hFFFFFFFE);
`else
    chk("ign_res_hi", bus.res_hi, 32'h0);
`endif
    chk("ign_busy", bus.busy, 1'b0);

    // Reset in the middle of an operation aborts it and clears results.
    issue(LONG_OP, 32'h00000007, 32'h00000009);
    repeat (KRST - 1) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_busy", bus.busy, 1'b1);
    chk("pre_rst_res_held", bus.res, 32'h00000001);
    base = done_cnt;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_res", bus.res, 32'h0);
    chk("mid_rst_res_hi", bus.res_hi, 32'h0);
    chk("mid_rst_zero", bus.zero, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt - base, 0);
    chk("mid_rst_idle", bus.busy, 1'b0);

    // Fresh AND after reset completes normally.
    issue(3'b000, 32'hF0F0F0F0, 32'h3C3C3C3C);
    wait_done(e);
    chk("post_rst_latency", e, 1);
    chk("post_rst_res", bus.res, 32'h30303030);
    chk("post_rst_zero", bus.zero, 1'b0);
    chk("post_rst_res_hi", bus.res_hi, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
